// File: rtl/spi_arb_pkg.sv
// spi_arb_pkg
//   Shared definitions for the two-master SPI flash arbiter:
//   - arb_state_t : arbiter FSM states
//   - M_DFU/M_AUX : master index constants (0 = DFU core, 1 = auxiliary reader)
//   - *_IDLE      : pin levels driven while no master owns the flash
package spi_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT0 = 2'd1,
    ST_GRANT1 = 2'd2,
    ST_GUARD  = 2'd3
  } arb_state_t;

  localparam logic M_DFU = 1'b0;
  localparam logic M_AUX = 1'b1;

  localparam logic CSEL_IDLE = 1'b1;
  localparam logic SCLK_IDLE = 1'b0;
  localparam logic MOSI_IDLE = 1'b0;
  localparam logic MISO_IDLE = 1'b1;

endpackage

// File: rtl/spi_arb_rr2.sv
// spi_arb_rr2
//   Two-way round-robin pick, purely combinational.
//   Ports:
//     req0, req1  : request lines of master 0 / master 1
//     last_owner  : index of the master that held the bus most recently
//     valid       : at least one request is pending
//     pick        : index of the master to grant (meaningful only when valid)
module spi_arb_rr2
  import spi_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_owner,
  output logic valid,
  output logic pick
);

  assign valid = req0 | req1;

  // On a tie the master that did not own the bus last goes first.
  always_comb begin
    pick = M_DFU;
    if (req0 && req1) begin
      pick = ~last_owner;
    end else if (req1) begin
      pick = M_AUX;
    end
  end

endmodule

// File: rtl/spi_flash_arbiter.sv
// spi_flash_arbiter
//   Shares the configuration SPI flash between the DFU core (master 0) and a
//   secondary reader (master 1). Whole transactions are granted (csel low to
//   csel high), a deselect guard gap separates owners, and over-long
//   ownership is flagged.
//   Ports:
//     clk, reset                  : system clock, async active-high reset
//     mN_req / mN_gnt             : request in, registered grant out
//     mN_csel/mN_sclk/mN_mosi     : SPI outputs of master N
//     mN_miso                     : flash_miso when master N is granted, else 1
//     flash_csel/sclk/mosi/miso   : flash pins (flash_sclk feeds USRMCLKI)
//     busy                        : arbiter is not idle
//     owner                       : current or most recent grantee
//     hold_overrun                : sticky flag, a grant lasted HOLD_LIMIT cycles
module spi_flash_arbiter
  import spi_arb_pkg::*;
#(
  parameter int GUARD_CYCLES = 4,
  parameter int HOLD_LIMIT   = 0,
  parameter int CNT_W        = 24
) (
  input  logic clk,
  input  logic reset,
  input  logic m0_req,
  output logic m0_gnt,
  input  logic m0_csel,
  input  logic m0_sclk,
  input  logic m0_mosi,
  output logic m0_miso,
  input  logic m1_req,
  output logic m1_gnt,
  input  logic m1_csel,
  input  logic m1_sclk,
  input  logic m1_mosi,
  output logic m1_miso,
  output logic flash_csel,
  output logic flash_sclk,
  output logic flash_mosi,
  input  logic flash_miso,
  output logic busy,
  output logic owner,
  output logic hold_overrun
);

  // A zero-cycle guard still needs a legal 1-bit counter; it is never loaded then.
  localparam int GW = (GUARD_CYCLES > 0) ? $clog2(GUARD_CYCLES + 1) : 1;
  localparam logic [GW-1:0]    GUARD_LOAD = GW'(GUARD_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_MATCH = CNT_W'(HOLD_LIMIT - 1);

  arb_state_t       state_q, state_d;
  logic             last_owner_q, last_owner_d;
  logic             owner_q, owner_d;
  logic [GW-1:0]    guard_cnt_q, guard_cnt_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             hold_overrun_q, hold_overrun_d;

  logic rr_valid;
  logic rr_pick;
  logic cur_idx;
  logic cur_req;
  logic cur_csel;

  spi_arb_rr2 u_rr (
    .req0       (m0_req),
    .req1       (m1_req),
    .last_owner (last_owner_q),
    .valid      (rr_valid),
    .pick       (rr_pick)
  );

  // Request/csel of whichever master currently holds the grant.
  assign cur_idx  = (state_q == ST_GRANT1);
  assign cur_req  = cur_idx ? m1_req  : m0_req;
  assign cur_csel = cur_idx ? m1_csel : m0_csel;

  // Release needs both req low and csel high, so a flash command is never cut.
  always_comb begin
    state_d        = state_q;
    last_owner_d   = last_owner_q;
    owner_d        = owner_q;
    guard_cnt_d    = guard_cnt_q;
    hold_cnt_d     = hold_cnt_q;
    hold_overrun_d = hold_overrun_q;
    case (state_q)
      ST_IDLE: begin
        if (rr_valid) begin
          state_d    = rr_pick ? ST_GRANT1 : ST_GRANT0;
          owner_d    = rr_pick;
          hold_cnt_d = '0;
        end
      end
      ST_GRANT0, ST_GRANT1: begin
        if (hold_cnt_q != '1) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
        if ((HOLD_LIMIT != 0) && (hold_cnt_q == HOLD_MATCH)) begin
          hold_overrun_d = 1'b1;
        end
        if (!cur_req && cur_csel) begin
          last_owner_d = cur_idx;
          if (GUARD_CYCLES == 0) begin
            state_d = ST_IDLE;
          end else begin
            state_d     = ST_GUARD;
            guard_cnt_d = GUARD_LOAD;
          end
        end
      end
      ST_GUARD: begin
        if (guard_cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          guard_cnt_d = guard_cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // last_owner and owner reset to 1 so master 0 wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      last_owner_q   <= M_AUX;
      owner_q        <= M_AUX;
      guard_cnt_q    <= '0;
      hold_cnt_q     <= '0;
      hold_overrun_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_owner_q   <= last_owner_d;
      owner_q        <= owner_d;
      guard_cnt_q    <= guard_cnt_d;
      hold_cnt_q     <= hold_cnt_d;
      hold_overrun_q <= hold_overrun_d;
    end
  end

  // Pin mux decodes the registered state only, so SPI signals pass with no
  // added latency and the flash deselects as soon as reset asserts.
  always_comb begin
    flash_csel = CSEL_IDLE;
    flash_sclk = SCLK_IDLE;
    flash_mosi = MOSI_IDLE;
    m0_miso    = MISO_IDLE;
    m1_miso    = MISO_IDLE;
    case (state_q)
      ST_GRANT0: begin
        flash_csel = m0_csel;
        flash_sclk = m0_sclk;
        flash_mosi = m0_mosi;
        m0_miso    = flash_miso;
      end
      ST_GRANT1: begin
        flash_csel = m1_csel;
        flash_sclk = m1_sclk;
        flash_mosi = m1_mosi;
        m1_miso    = flash_miso;
      end
      default: ;
    endcase
  end

  assign m0_gnt       = (state_q == ST_GRANT0);
  assign m1_gnt       = (state_q == ST_GRANT1);
  assign busy         = (state_q != ST_IDLE);
  assign owner        = owner_q;
  assign hold_overrun = hold_overrun_q;

endmodule
